// File: rtl/mcs4_timing_gen_if.sv
// Output bundle of the MCS-4 timing generator: two-phase clocks, phase ring, sync and step.
interface mcs4_timing_gen_if;
  logic       clk1;
  logic       clk2;
  logic [0:7] phase;
  logic       sync;
  logic       step;

  modport master (output clk1, clk2, phase, sync, step);
  modport slave  (input  clk1, clk2, phase, sync, step);
endinterface

// File: rtl/mcs4_timing_gen.sv
// Divides sysclk into non-overlapping clk1/clk2 and runs the self-starting
// 8-state master/slave phase ring (A1 A2 A3 M1 M2 X1 X2 X3).
module mcs4_timing_gen #(
  parameter int DIV        = 20,
  parameter int CLK1_W     = 5,
  parameter int CLK2_START = 10,
  parameter int CLK2_W     = 5
) (
  input  logic               sysclk,
  input  logic               reset_n,
  mcs4_timing_gen_if.master  tim
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CLK1_OFF = CNT_W'(CLK1_W);
  localparam logic [CNT_W-1:0] CLK2_ON  = CNT_W'(CLK2_START);
  localparam logic [CNT_W-1:0] CLK2_OFF = CNT_W'(CLK2_START + CLK2_W);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             clk1_r;
  logic             clk2_r;
  logic [0:7]       master_ring;
  logic [0:7]       phase_ring;

  always_comb begin
    cnt_next = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
  end

  // Master ring loads at clk2 fall, slave copies it at clk1 rise; an empty
  // upper ring injects a 1, so the ring self-starts and flushes extra bits.
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      cnt         <= '0;
      clk1_r      <= 1'b0;
      clk2_r      <= 1'b0;
      master_ring <= '0;
      phase_ring  <= '0;
    end else begin
      cnt <= cnt_next;

      if (cnt_next == '0)
        clk1_r <= 1'b1;
      else if (cnt_next == CLK1_OFF)
        clk1_r <= 1'b0;

      if (cnt_next == CLK2_ON)
        clk2_r <= 1'b1;
      else if (cnt_next == CLK2_OFF)
        clk2_r <= 1'b0;

      if (cnt_next == CLK2_OFF)
        master_ring <= {~|phase_ring[0:6], phase_ring[0:6]};

      if (cnt_next == '0)
        phase_ring <= master_ring;
    end
  end

  assign tim.clk1  = clk1_r;
  assign tim.clk2  = clk2_r;
  assign tim.phase = phase_ring;
  assign tim.sync  = master_ring[7];
  // phase only moves while clk2 is low, so this AND cannot glitch
  assign tim.step  = phase_ring[7] & clk2_r;

endmodule
